// File: rtl/dma_prog_pkg.sv
// dma_prog_pkg: shared types and constants for the DMA programming master.
//   - state_t      : FSM state encoding
//   - REG_*        : DMA controller register codes
//   - DEF_*        : default bus timing (clocks)
//   - bus_cycle()  : address/data/direction of bus cycle <idx> of a command
//   - num_cycles() : number of bus cycles per command
// Build option: DMA_PROG_AUTO_FF_CLEAR_EN inserts a byte-pointer clear write
// (address 4'hC, data 8'h00) ahead of every 16-bit access.
package dma_prog_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [3:0] REG_COMMAND  = 4'h8;
    localparam logic [3:0] REG_MODE     = 4'hB;
    localparam logic [3:0] REG_CLEAR_FF = 4'hC;
    localparam logic [3:0] REG_STATUS   = 4'h8;

    localparam int DEF_SETUP_CYCLES  = 1;
    localparam int DEF_STROBE_CYCLES = 2;

`ifdef DMA_PROG_AUTO_FF_CLEAR_EN
    localparam bit AUTO_FF_CLEAR = 1'b1;
`else
    localparam bit AUTO_FF_CLEAR = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
        logic       wr;
        logic       hi;   // this cycle carries the high byte
    } bus_cyc_t;

    // Describe bus cycle <idx> of a command; the optional clear cycle is slot 0.
    function automatic bus_cyc_t bus_cycle(input logic [1:0]  idx,
                                           input logic        write,
                                           input logic        word,
                                           input logic [3:0]  addr,
                                           input logic [15:0] wdata);
        bus_cyc_t   c;
        logic [1:0] didx;
        if (AUTO_FF_CLEAR && word && (idx == 2'd0)) begin
            c.addr = REG_CLEAR_FF;
            c.data = 8'h00;
            c.wr   = 1'b1;
            c.hi   = 1'b0;
        end else begin
            didx   = (AUTO_FF_CLEAR && word) ? (idx - 2'd1) : idx;
            c.addr = addr;
            c.wr   = write;
            c.hi   = word && (didx == 2'd1);
            c.data = c.hi ? wdata[15:8] : wdata[7:0];
        end
        return c;
    endfunction

    // Bus cycles needed for one command.
    function automatic logic [1:0] num_cycles(input logic word);
        if (!word) begin
            return 2'd1;
        end else if (AUTO_FF_CLEAR) begin
            return 2'd3;
        end else begin
            return 2'd2;
        end
    endfunction

endpackage

// File: rtl/dma_prog_waitcnt.sv
// dma_prog_waitcnt: loadable 4-bit wait-state down-counter.
//   CLK, RESET  : clock, synchronous active-high reset
//   load        : load load_value this clock (has priority over counting)
//   load_value  : value to load
//   zero        : counter is at 0 (counting stops there)
module dma_prog_waitcnt (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic       zero
);
    logic [3:0] count;

    // Load on state entry, otherwise count down and park at zero.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_value;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end else begin
            count <= count;
        end
    end

    assign zero = (count == 4'd0);
endmodule

// File: rtl/dma_prog_master.sv
// dma_prog_master: executes 8/16-bit register reads and writes on an
// 8-bit ISA-style DMA controller bus (CS_N, A, IOR_N/IOW_N, DB_*).
//   CLK, RESET            : clock, synchronous active-high reset
//   req_* (valid/ready)   : command handshake; fields captured on accept
//   rsp_valid, rsp_rdata  : one-clock completion pulse, read data (held)
//   CS_N, IOR_N, IOW_N, A : bus control and register address
//   DB_OUT, DB_OE, DB_IN  : data bus write byte, drive enable, read byte
// Parameters: SETUP_CYCLES (1..15), STROBE_CYCLES (1..15).
// Build option: DMA_PROG_AUTO_FF_CLEAR_EN (see dma_prog_pkg).
module dma_prog_master
    import dma_prog_pkg::*;
#(
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_word,
    input  logic [3:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        CS_N,
    output logic        IOR_N,
    output logic        IOW_N,
    output logic [3:0]  A,
    output logic [7:0]  DB_OUT,
    output logic        DB_OE,
    input  logic [7:0]  DB_IN
);
    // Counter holds "clocks remaining minus one" so zero marks the last clock.
    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    state_t      state;
    logic        cmd_write;
    logic        cmd_word;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic [1:0]  cyc_idx;
    logic [1:0]  cyc_total;
    logic        cur_wr;
    logic        cur_hi;
    logic [15:0] rd_acc;

    logic        accept;
    logic        last_cycle;
    logic        cnt_load;
    logic [3:0]  cnt_load_value;
    logic        cnt_zero;
    bus_cyc_t    first_cyc;
    bus_cyc_t    next_cyc;

    assign accept     = req_valid && req_ready;
    assign last_cycle = (cyc_idx == (cyc_total - 2'd1));
    // Cycle 0 comes straight from the request so the bus is set up on the accept edge.
    assign first_cyc  = bus_cycle(2'd0, req_write, req_word, req_addr, req_wdata);
    assign next_cyc   = bus_cycle(cyc_idx + 2'd1, cmd_write, cmd_word, cmd_addr, cmd_wdata);

    dma_prog_waitcnt u_waitcnt (
        .CLK        (CLK),
        .RESET      (RESET),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .zero       (cnt_zero)
    );

    // Reload the wait counter with the length of the state being entered.
    always_comb begin
        cnt_load       = 1'b0;
        cnt_load_value = 4'd0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_load       = 1'b1;
                    cnt_load_value = SETUP_LOAD;
                end else begin
                    cnt_load = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    cnt_load       = 1'b1;
                    cnt_load_value = STROBE_LOAD;
                end else begin
                    cnt_load = 1'b0;
                end
            end
            STROBE: begin
                if (cnt_zero) begin
                    cnt_load       = 1'b1;
                    cnt_load_value = 4'd0;
                end else begin
                    cnt_load = 1'b0;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    cnt_load       = 1'b1;
                    cnt_load_value = last_cycle ? 4'd0 : SETUP_LOAD;
                end else begin
                    cnt_load = 1'b0;
                end
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    // Bus sequencing FSM; all bus and handshake outputs are registered here.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'h0000;
            CS_N      <= 1'b1;
            IOR_N     <= 1'b1;
            IOW_N     <= 1'b1;
            A         <= 4'h0;
            DB_OUT    <= 8'h00;
            DB_OE     <= 1'b0;
            cmd_write <= 1'b0;
            cmd_word  <= 1'b0;
            cmd_addr  <= 4'h0;
            cmd_wdata <= 16'h0000;
            cyc_idx   <= 2'd0;
            cyc_total <= 2'd1;
            cur_wr    <= 1'b0;
            cur_hi    <= 1'b0;
            rd_acc    <= 16'h0000;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        cmd_write <= req_write;
                        cmd_word  <= req_word;
                        cmd_addr  <= req_addr;
                        cmd_wdata <= req_wdata;
                        cyc_idx   <= 2'd0;
                        cyc_total <= num_cycles(req_word);
                        rd_acc    <= 16'h0000;
                        req_ready <= 1'b0;
                        CS_N      <= 1'b0;
                        A         <= first_cyc.addr;
                        DB_OUT    <= first_cyc.data;
                        DB_OE     <= first_cyc.wr;
                        cur_wr    <= first_cyc.wr;
                        cur_hi    <= first_cyc.hi;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_zero) begin
                        IOW_N <= ~cur_wr;
                        IOR_N <= cur_wr;
                        state <= STROBE;
                    end
                end
                STROBE: begin
                    if (cnt_zero) begin
                        IOW_N <= 1'b1;
                        IOR_N <= 1'b1;
                        // Read data is taken on the final strobe clock.
                        if (!cur_wr) begin
                            if (cur_hi) begin
                                rd_acc[15:8] <= DB_IN;
                            end else begin
                                rd_acc[7:0] <= DB_IN;
                            end
                        end
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        if (last_cycle) begin
                            CS_N      <= 1'b1;
                            DB_OE     <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rd_acc;
                            state     <= RESP;
                        end else begin
                            cyc_idx <= cyc_idx + 2'd1;
                            A       <= next_cyc.addr;
                            DB_OUT  <= next_cyc.data;
                            DB_OE   <= next_cyc.wr;
                            cur_wr  <= next_cyc.wr;
                            cur_hi  <= next_cyc.hi;
                            state   <= SETUP;
                        end
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dma_prog_master.sv
// tb_dma_prog_master: scoreboard bench for dma_prog_master (S=1, T=2).
// Stimulus pushes expected bus cycles, read bytes and responses into queues;
// a negedge monitor pops and compares them as the DUT produces them.
// Honours DMA_PROG_AUTO_FF_CLEAR_EN for the expected clear cycle.
module tb_dma_prog_master;
    localparam int S = 1;
    localparam int T = 2;
`ifdef DMA_PROG_AUTO_FF_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        RESET;
    logic        req_valid, req_ready, req_write, req_word;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        CS_N, IOR_N, IOW_N, DB_OE;
    logic [3:0]  A;
    logic [7:0]  DB_OUT;
    logic [7:0]  rd_byte = 8'hEE;

    typedef struct packed {logic [3:0] a; logic [7:0] d; logic wr;} bus_t;
    typedef struct {logic [15:0] rdata; int lat;} rsp_t;

    bus_t       bus_q[$];
    logic [7:0] rd_q[$];
    rsp_t       exp_q[$];
    int         acc_q[$];

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    dma_prog_master #(.SETUP_CYCLES(S), .STROBE_CYCLES(T)) dut (
        .CLK(clk), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .A(A),
        .DB_OUT(DB_OUT), .DB_OE(DB_OE), .DB_IN(rd_byte)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    logic       prev_strobe = 1'b0;
    logic       prev_ior_n  = 1'b1;
    logic       prev_rsp    = 1'b0;
    int         strobe_w    = 0;
    logic [15:0] last_rdata = 16'h0000;

    always @(negedge clk) begin
        bus_t e;
        rsp_t r;
        int   a;
        logic strobe;
        if (RESET) begin
            bus_q.delete(); rd_q.delete(); exp_q.delete(); acc_q.delete();
            prev_strobe = 1'b0; prev_ior_n = 1'b1; prev_rsp = 1'b0;
            strobe_w = 0; last_rdata = 16'h0000; rd_byte = 8'hEE;
        end else begin
            strobe = !IOR_N || !IOW_N;
            chk("strobe_overlap", !IOR_N && !IOW_N, 32'd0);
            if (strobe) begin
                chk("cs_in_strobe", CS_N, 32'd0);
                chk("ready_busy", req_ready, 32'd0);
                if (!prev_strobe) begin
                    chk("bus_expected", bus_q.size() > 0, 32'd1);
                    if (bus_q.size() > 0) begin
                        e = bus_q.pop_front();
                        chk("bus_addr", A, e.a);
                        chk("bus_dir", !IOW_N, e.wr);
                        chk("bus_oe", DB_OE, e.wr);
                        if (e.wr) chk("bus_data", DB_OUT, e.d);
                    end
                    strobe_w = 1;
                end else begin
                    strobe_w++;
                end
            end else if (prev_strobe) begin
                chk("strobe_width", strobe_w, T);
            end
            // Present the next read byte for the duration of each read strobe.
            if (!IOR_N && prev_ior_n) begin
                rd_byte = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
            end else if (IOR_N) begin
                rd_byte = 8'hEE;
            end
            if (req_ready) chk("cs_idle", CS_N, 32'd1);
            if (rsp_valid) begin
                chk("rsp_pulse", prev_rsp, 32'd0);
                chk("rsp_cs", CS_N, 32'd1);
                chk("rsp_expected", (exp_q.size() > 0) && (acc_q.size() > 0), 32'd1);
                if ((exp_q.size() > 0) && (acc_q.size() > 0)) begin
                    r = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("rsp_latency", cyc_cnt - a + 1, r.lat);
                    last_rdata = r.rdata;
                end
            end else begin
                chk("rdata_hold", rsp_rdata, last_rdata);
            end
            if (req_valid && req_ready) acc_q.push_back(cyc_cnt + 1);
            prev_strobe = strobe;
            prev_ior_n  = IOR_N;
            prev_rsp    = rsp_valid;
        end
    end

    // Issue one command; called just after a posedge.
    task automatic issue(input logic wr, input logic word, input logic [3:0] addr,
                         input logic [15:0] wdata, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [15:0] exp_rdata, input bit hold);
        int   n;
        int   i;
        rsp_t r;
        if (CLR && word) bus_q.push_back({4'hC, 8'h00, 1'b1});
        bus_q.push_back({addr, wdata[7:0], wr});
        if (word) bus_q.push_back({addr, wdata[15:8], wr});
        if (!wr) begin
            rd_q.push_back(b0);
            if (word) rd_q.push_back(b1);
        end
        n = word ? (CLR ? 3 : 2) : 1;
        r.rdata = exp_rdata;
        r.lat   = n * (S + T + 1) + 1;
        exp_q.push_back(r);
        req_write = wr; req_word = word; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        i = 0;
        while (i < 100) begin
            @(negedge clk);
            if (req_ready === 1'b1) break;
            i++;
        end
        chk("accept_timeout", i < 100, 32'd1);
        @(posedge clk); #2;
        // Scramble fields after accept: the DUT must already have captured them.
        req_write = ~wr; req_word = ~word; req_addr = 4'hF; req_wdata = 16'hFFFF;
        req_valid = hold;
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((exp_q.size() != 0 || req_ready !== 1'b1) && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk("idle_timeout", i < 300, 32'd1);
        @(posedge clk); #2;
    endtask

    initial begin
        int i;
        RESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0;
        req_addr = 4'h0; req_wdata = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", CS_N, 32'd1);
        chk("rst_ior_n", IOR_N, 32'd1);
        chk("rst_iow_n", IOW_N, 32'd1);
        chk("rst_a", A, 32'd0);
        chk("rst_db_oe", DB_OE, 32'd0);
        chk("rst_db_out", DB_OUT, 32'd0);
        chk("rst_ready", req_ready, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        RESET = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", req_ready, 32'd1);
        @(posedge clk); #2;

        issue(1'b1, 1'b0, 4'h8, 16'h00A5, 8'h00, 8'h00, 16'h0000, 1'b0); wait_idle();
        issue(1'b0, 1'b0, 4'h8, 16'h0000, 8'h3C, 8'h00, 16'h003C, 1'b0); wait_idle();
        issue(1'b1, 1'b1, 4'h0, 16'h1234, 8'h00, 8'h00, 16'h0000, 1'b0); wait_idle();
        issue(1'b0, 1'b1, 4'h1, 16'h0000, 8'hCD, 8'hAB, 16'hABCD, 1'b0); wait_idle();

        // Reset on the second strobe clock of a word write.
        issue(1'b1, 1'b1, 4'h2, 16'h5566, 8'h00, 8'h00, 16'h0000, 1'b0);
        i = 0;
        while (IOW_N !== 1'b0 && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("rst_strobe_seen", i < 50, 32'd1);
        @(posedge clk); #2;
        chk("rst_in_strobe2", IOW_N, 32'd0);
        RESET = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_cs_n", CS_N, 32'd1);
        chk("mid_rst_iow_n", IOW_N, 32'd1);
        chk("mid_rst_ior_n", IOR_N, 32'd1);
        chk("mid_rst_a", A, 32'd0);
        chk("mid_rst_db_oe", DB_OE, 32'd0);
        chk("mid_rst_db_out", DB_OUT, 32'd0);
        chk("mid_rst_ready", req_ready, 32'd0);
        chk("mid_rst_rsp_valid", rsp_valid, 32'd0);
        RESET = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_ready_after", req_ready, 32'd1);
        repeat (12) @(posedge clk);
        #1;
        @(posedge clk); #2;

        issue(1'b1, 1'b0, 4'hB, 16'h005A, 8'h00, 8'h00, 16'h0000, 1'b0); wait_idle();

        // Back-to-back with req_valid held high.
        issue(1'b0, 1'b0, 4'h8, 16'h0000, 8'h81, 8'h00, 16'h0081, 1'b1);
        issue(1'b1, 1'b1, 4'h2, 16'hBEEF, 8'h00, 8'h00, 16'h0000, 1'b1);
        issue(1'b0, 1'b1, 4'h3, 16'h0000, 8'h11, 8'h22, 16'h2211, 1'b0);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("drain_rsp", exp_q.size(), 32'd0);
        chk("drain_bus", bus_q.size(), 32'd0);
        chk("drain_accept", acc_q.size(), 32'd0);
        chk("drain_rd", rd_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dma_prog_master.md
DMA_PROG_MASTER -- requirements
Module: dma_prog_master

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named CLK and RESET.
REQ-002 Parameter SETUP_CYCLES SHALL default to 1 and SHALL set the number of clocks that CS_N and A[3:0] are valid before the strobe asserts; legal range is 1..15.
REQ-003 Parameter STROBE_CYCLES SHALL default to 2 and SHALL set the number of clocks that IOR_N or IOW_N is held low; legal range is 1..15.
REQ-004 The ports SHALL be, clock and reset first:
- CLK in 1: clock.
- RESET in 1: synchronous reset.
- req_valid in 1: command request.
- req_ready out 1: command accepted while req_valid and req_ready are both high.
- req_write in 1: 1 = register write, 0 = register read.
- req_word in 1: 1 = 16-bit access (low byte, then high byte), 0 = 8-bit access.
- req_addr in 4: register code {A3,A2,A1,A0}.
- req_wdata in 16: write data.
- rsp_valid out 1: single-cycle completion pulse.
- rsp_rdata out 16: read result.
- CS_N out 1: chip select.
- IOR_N out 1: read strobe.
- IOW_N out 1: write strobe.
- A out 4: register address.
- DB_OUT out 8: write byte.
- DB_OE out 1: data bus drive enable.
- DB_IN in 8: read byte.

Function
REQ-005 req_ready SHALL be high only in state IDLE; no request SHALL be accepted at any other time.
REQ-006 The FSM SHALL use the states IDLE, SETUP, STROBE, HOLD and RESP.
- IDLE goes to SETUP on accept.
- SETUP goes to STROBE after SETUP_CYCLES clocks.
- STROBE goes to HOLD after STROBE_CYCLES clocks.
- HOLD goes to SETUP if bus cycles remain, otherwise to RESP.
- RESP goes to IDLE after 1 clock.
REQ-007 In SETUP, STROBE and HOLD, CS_N SHALL be 0 and A SHALL equal the current bus-cycle address.
REQ-008 In STROBE only, IOW_N SHALL be 0 for writes and IOR_N SHALL be 0 for reads; IOR_N and IOW_N SHALL never be low together.
REQ-009 For writes, DB_OE SHALL be 1 and DB_OUT SHALL be stable throughout SETUP, STROBE and HOLD; for reads, DB_OE SHALL be 0.
REQ-010 For reads, DB_IN SHALL be sampled on the last STROBE clock: the first byte goes to rsp_rdata[7:0] and the second byte to rsp_rdata[15:8].
REQ-011 An 8-bit read SHALL return {8'h00, byte}.
REQ-012 For req_word=1, the low byte SHALL be transferred first and then the high byte, both to the same req_addr.
REQ-013 Total latency SHALL be N*(SETUP_CYCLES+STROBE_CYCLES+1)+1 clocks from the accept edge to rsp_valid, where N is the number of bus cycles (1..3).
REQ-014 rsp_valid SHALL be high for exactly one clock, in RESP, and rsp_rdata SHALL hold its value until the next RESP.
REQ-015 req_valid dropping after acceptance SHALL have no effect; the request fields SHALL be captured at the accept edge.
REQ-016 The wait-state counter SHALL be 4 bits wide, SHALL load at each state entry and SHALL count down to 0.

Reset
REQ-017 On RESET, including mid-operation, the next edge SHALL force state IDLE, the in-flight command SHALL be dropped, and no response SHALL be issued.
REQ-018 Reset values SHALL be: CS_N=1, IOR_N=1, IOW_N=1, A=0, DB_OE=0, DB_OUT=0, req_ready=0 during RESET, rsp_valid=0, rsp_rdata=0.

Configuration
REQ-019 When DMA_PROG_AUTO_FF_CLEAR_EN is defined, each req_word access SHALL be preceded by one write bus cycle to address 4'hC with data 8'h00 (clear byte-pointer flip-flop), giving N=3.
REQ-020 When DMA_PROG_AUTO_FF_CLEAR_EN is undefined, no clear cycle SHALL be issued and a word access SHALL have N=2.

Structure
REQ-021 A shared package dma_prog_pkg SHALL hold:
- the FSM state enum;
- the register-code constants (command 4'h8, mode 4'hB, clear-FF 4'hC, status read 4'h8);
- the default timing localparams.
REQ-022 One sub-module, dma_prog_waitcnt (the loadable 4-bit down-counter with a zero flag), SHALL be used; everything else SHALL be flat.

Verification
REQ-023 With S=1, T=2: an 8-bit write of 8'hA5 to addr 4'h8 -> one IOW_N pulse of 2 clocks, DB_OUT=8'hA5, A=4'h8, rsp_valid 5 clocks after accept.
REQ-024 An 8-bit read from addr 4'h8 with DB_IN=8'h3C during STROBE -> IOR_N low for 2 clocks, rsp_rdata=16'h003C, DB_OE=0 throughout.
REQ-025 A word write of 16'h1234 to addr 4'h0 with the macro defined -> bus cycles (C,00), (0,34), (0,12); rsp_valid at 13 clocks. With the macro undefined -> (0,34), (0,12); rsp_valid at 9 clocks.
REQ-026 A word read from addr 4'h1 with DB_IN giving 8'hCD then 8'hAB -> rsp_rdata=16'hABCD.
REQ-027 RESET asserted on the second STROBE clock of a word write -> outputs at their reset values on the next edge, no rsp_valid, req_ready=1 the clock after RESET falls.
REQ-028 req_valid held high continuously with back-to-back requests -> each accepted only in IDLE, CS_N high for at least 1 clock (RESP) between commands, no request lost or duplicated.
